// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/memory request protocol: word type, RAM status,
// arbiter state encoding and the poison word returned on failed accesses.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } arb_state_t;

    typedef enum logic {
        DATA  = 1'b0,
        INSTR = 1'b1
    } grant_t;

    localparam word_t BAD_WORD = 32'hBAD1BAD1;

endpackage

// File: rtl/mem_arbiter_ctrl_if.sv
// Cache-side and RAM-side handshake bundle of the memory arbiter.
interface mem_arbiter_ctrl_if #(
    parameter int WORD_W = 32
);
    import cpu_types_pkg::*;

    logic              dREN;
    logic              dWEN;
    logic [WORD_W-1:0] daddr;
    logic [WORD_W-1:0] dstore;
    logic              dwait;
    logic [WORD_W-1:0] dload;
    logic              iREN;
    logic [WORD_W-1:0] iaddr;
    logic              iwait;
    logic [WORD_W-1:0] iload;
    logic              ramREN;
    logic              ramWEN;
    logic [WORD_W-1:0] ramaddr;
    logic [WORD_W-1:0] ramstore;
    logic [WORD_W-1:0] ramload;
    ramstate_t         ramstate;

    modport slave (
        input  dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
        output dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
        input  dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/arb_watchdog.sv
// Saturating 8-bit grant watchdog: counts stalled grant cycles and flags
// expiry once the count reaches TIMEOUT.
module arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    logic [7:0] count_r;

    // Stall counter; saturates so a stuck grant can never wrap back to "fresh".
    always_ff @(posedge CLK) begin
        if (RST) begin
            count_r <= 8'd0;
        end else if (clr) begin
            count_r <= 8'd0;
        end else if (en && (count_r != 8'hFF)) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r >= LIMIT);

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// Memory-side responder: round-robin arbitration of data and instruction cache
// requests onto one RAM port, with watchdog, sticky bus error and access counters.
module mem_arbiter_ctrl
    import cpu_types_pkg::*;
#(
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST,
    mem_arbiter_ctrl_if.slave bus,
    output logic              bus_err,
    output logic [31:0]       dcount,
    output logic [31:0]       icount
);

    arb_state_t  state_r, state_nxt_s;
    grant_t      last_grant_r;
    logic        bus_err_r;
    logic [31:0] dcount_r, icount_r;
    logic        dreq_s, d_done_s, i_done_s, err_s, wd_en_s, wd_expired_s;

    assign dreq_s  = bus.dREN | bus.dWEN;
    assign bus_err = bus_err_r;
    assign dcount  = dcount_r;
    assign icount  = icount_r;

    arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .CLK     (CLK),
        .RST     (RST),
        .clr     (state_r == IDLE),
        .en      (wd_en_s),
        .expired (wd_expired_s)
    );

    // Next-state, RAM mux and cache handshake; RST masks everything so an
    // abandoned access never releases a wait.
    always_comb begin
        state_nxt_s  = state_r;
        bus.dwait    = 1'b1;
        bus.iwait    = 1'b1;
        bus.dload    = {WORD_W{1'b0}};
        bus.iload    = {WORD_W{1'b0}};
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = {WORD_W{1'b0}};
        bus.ramstore = {WORD_W{1'b0}};
        d_done_s     = 1'b0;
        i_done_s     = 1'b0;
        err_s        = 1'b0;
        wd_en_s      = 1'b0;
        if (RST) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (dreq_s && bus.iREN) begin
                        state_nxt_s = (last_grant_r == INSTR) ? DGRANT : IGRANT;
                    end else if (dreq_s) begin
                        state_nxt_s = DGRANT;
                    end else if (bus.iREN) begin
                        state_nxt_s = IGRANT;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                DGRANT: begin
                    bus.ramaddr  = bus.daddr;
                    bus.ramstore = bus.dstore;
                    bus.ramWEN   = bus.dWEN;
                    bus.ramREN   = bus.dREN & ~bus.dWEN;
                    if (!dreq_s) begin
                        state_nxt_s = IDLE;
                    end else if (bus.ramstate == ACCESS) begin
                        bus.dwait   = 1'b0;
                        bus.dload   = bus.dWEN ? {WORD_W{1'b0}} : bus.ramload;
                        d_done_s    = 1'b1;
                        state_nxt_s = IDLE;
                    end else if ((bus.ramstate == ERROR) || wd_expired_s) begin
                        bus.dwait   = 1'b0;
                        bus.dload   = WORD_W'(BAD_WORD);
                        err_s       = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        wd_en_s = 1'b1;
                    end
                end
                IGRANT: begin
                    bus.ramREN  = 1'b1;
                    bus.ramaddr = bus.iaddr;
                    if (!bus.iREN) begin
                        state_nxt_s = IDLE;
                    end else if (bus.ramstate == ACCESS) begin
                        bus.iwait   = 1'b0;
                        bus.iload   = bus.ramload;
                        i_done_s    = 1'b1;
                        state_nxt_s = IDLE;
                    end else if ((bus.ramstate == ERROR) || wd_expired_s) begin
                        bus.iwait   = 1'b0;
                        bus.iload   = WORD_W'(BAD_WORD);
                        err_s       = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        wd_en_s = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // State, round-robin history, sticky error and completion counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= IDLE;
            last_grant_r <= INSTR;
            bus_err_r    <= 1'b0;
            dcount_r     <= 32'd0;
            icount_r     <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            if (d_done_s) begin
                dcount_r     <= dcount_r + 32'd1;
                last_grant_r <= DATA;
            end else if (i_done_s) begin
                icount_r     <= icount_r + 32'd1;
                last_grant_r <= INSTR;
            end else begin
                last_grant_r <= last_grant_r;
            end
            if (err_s) begin
                bus_err_r <= 1'b1;
            end else begin
                bus_err_r <= bus_err_r;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Self-checking bench for mem_arbiter_ctrl: vector table, directed corner
// sequences and randomized traffic against a transaction-level model.
module tb_mem_arbiter_ctrl;
    import cpu_types_pkg::*;

    localparam int TIMEOUT = 255;

    logic        CLK;
    logic        RST;
    logic        bus_err;
    logic [31:0] dcount, icount;
    int          checks;
    int          failures;

    mem_arbiter_ctrl_if #(.WORD_W(32)) bus ();

    mem_arbiter_ctrl #(.WORD_W(32), .TIMEOUT(TIMEOUT)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .bus     (bus),
        .bus_err (bus_err),
        .dcount  (dcount),
        .icount  (icount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        d_ren, d_wen, i_ren;
        logic [31:0] daddr, dstore, iaddr, ramload;
        ramstate_t   rs;
        logic        e_dwait, e_iwait, e_ren, e_wen;
        logic [31:0] e_raddr, e_rstore, e_dload, e_iload, e_dcnt, e_icnt;
    } vec_t;

    vec_t vecs[10];

    // transaction model state: owner 0=none 1=data 2=instr
    int          m_own, m_last, m_age;
    logic [31:0] m_dc, m_ic;
    logic        m_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_in(input logic dr, input logic dw, input logic ir,
                          input logic [31:0] da, input logic [31:0] ds,
                          input logic [31:0] ia, input logic [31:0] rl,
                          input ramstate_t rs);
        bus.dREN = dr; bus.dWEN = dw; bus.iREN = ir;
        bus.daddr = da; bus.dstore = ds; bus.iaddr = ia;
        bus.ramload = rl; bus.ramstate = rs;
        #3;
    endtask

    task automatic reset_dut();
        bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.iREN = 1'b0;
        bus.ramstate = FREE;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        m_own = 0; m_last = 2; m_age = 0; m_dc = 32'd0; m_ic = 32'd0; m_err = 1'b0;
    endtask

    task automatic model_check();
        logic        dreq, e_dw, e_iw, e_ren, e_wen, inc_d, inc_i, set_err;
        logic [31:0] e_addr, e_store, e_dl, e_il;
        int          nxt;
        dreq = bus.dREN | bus.dWEN;
        e_dw = 1'b1; e_iw = 1'b1; e_ren = 1'b0; e_wen = 1'b0;
        e_addr = 32'd0; e_store = 32'd0; e_dl = 32'd0; e_il = 32'd0;
        inc_d = 1'b0; inc_i = 1'b0; set_err = 1'b0; nxt = m_own;
        if (m_own == 0) begin
            if (dreq && bus.iREN) nxt = (m_last == 2) ? 1 : 2;
            else if (dreq)        nxt = 1;
            else if (bus.iREN)    nxt = 2;
            else                  nxt = 0;
            m_age = 0;
        end else if (m_own == 1) begin
            e_addr = bus.daddr; e_store = bus.dstore;
            e_wen = bus.dWEN; e_ren = bus.dREN & ~bus.dWEN;
            if (!dreq) nxt = 0;
            else if (bus.ramstate == ACCESS) begin
                e_dw = 1'b0; e_dl = bus.dWEN ? 32'd0 : bus.ramload; inc_d = 1'b1; nxt = 0;
            end else if (bus.ramstate == ERROR || m_age >= TIMEOUT) begin
                e_dw = 1'b0; e_dl = BAD_WORD; set_err = 1'b1; nxt = 0;
            end else m_age++;
        end else begin
            e_ren = 1'b1; e_addr = bus.iaddr;
            if (!bus.iREN) nxt = 0;
            else if (bus.ramstate == ACCESS) begin
                e_iw = 1'b0; e_il = bus.ramload; inc_i = 1'b1; nxt = 0;
            end else if (bus.ramstate == ERROR || m_age >= TIMEOUT) begin
                e_iw = 1'b0; e_il = BAD_WORD; set_err = 1'b1; nxt = 0;
            end else m_age++;
        end
        chk("rnd_dwait",    {31'd0, bus.dwait},  {31'd0, e_dw});
        chk("rnd_iwait",    {31'd0, bus.iwait},  {31'd0, e_iw});
        chk("rnd_dload",    bus.dload,           e_dl);
        chk("rnd_iload",    bus.iload,           e_il);
        chk("rnd_ramREN",   {31'd0, bus.ramREN}, {31'd0, e_ren});
        chk("rnd_ramWEN",   {31'd0, bus.ramWEN}, {31'd0, e_wen});
        chk("rnd_ramaddr",  bus.ramaddr,         e_addr);
        chk("rnd_ramstore", bus.ramstore,        e_store);
        chk("rnd_bus_err",  {31'd0, bus_err},    {31'd0, m_err});
        chk("rnd_dcount",   dcount,              m_dc);
        chk("rnd_icount",   icount,              m_ic);
        if (inc_d) begin m_dc = m_dc + 32'd1; m_last = 1; end
        if (inc_i) begin m_ic = m_ic + 32'd1; m_last = 2; end
        if (set_err) m_err = 1'b1;
        m_own = nxt;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [3:0]  seq;
        int          nrel, last_c, n;
        logic        saw_low;
        logic [31:0] cap;
        logic        r_d, r_w, r_i;
        int          x;
        ramstate_t   rs;

        checks = 0; failures = 0;
        RST = 1'b0;
        bus.daddr = 32'd0; bus.dstore = 32'd0; bus.iaddr = 32'd0; bus.ramload = 32'd0;

        vecs[0] = '{1'b1,1'b0,1'b0, 32'h100,32'h0,32'h0,32'h0,FREE,   1'b1,1'b1,1'b0,1'b0, 32'h0,32'h0,32'h0,32'h0,32'd0,32'd0};
        vecs[1] = '{1'b1,1'b0,1'b0, 32'h100,32'h0,32'h0,32'h0,BUSY,   1'b1,1'b1,1'b1,1'b0, 32'h100,32'h0,32'h0,32'h0,32'd0,32'd0};
        vecs[2] = '{1'b1,1'b0,1'b0, 32'h100,32'h0,32'h0,32'h0,BUSY,   1'b1,1'b1,1'b1,1'b0, 32'h100,32'h0,32'h0,32'h0,32'd0,32'd0};
        vecs[3] = '{1'b1,1'b0,1'b0, 32'h100,32'h0,32'h0,32'hDEADBEEF,ACCESS, 1'b0,1'b1,1'b1,1'b0, 32'h100,32'h0,32'hDEADBEEF,32'h0,32'd0,32'd0};
        vecs[4] = '{1'b1,1'b1,1'b0, 32'h3100,32'h12345678,32'h0,32'h0,FREE, 1'b1,1'b1,1'b0,1'b0, 32'h0,32'h0,32'h0,32'h0,32'd1,32'd0};
        vecs[5] = '{1'b1,1'b1,1'b0, 32'h3100,32'h12345678,32'h0,32'h0,BUSY, 1'b1,1'b1,1'b0,1'b1, 32'h3100,32'h12345678,32'h0,32'h0,32'd1,32'd0};
        vecs[6] = '{1'b1,1'b1,1'b0, 32'h3100,32'h12345678,32'h0,32'h55,ACCESS, 1'b0,1'b1,1'b0,1'b1, 32'h3100,32'h12345678,32'h0,32'h0,32'd1,32'd0};
        vecs[7] = '{1'b0,1'b0,1'b1, 32'h0,32'h0,32'h200,32'h0,FREE,   1'b1,1'b1,1'b0,1'b0, 32'h0,32'h0,32'h0,32'h0,32'd2,32'd0};
        vecs[8] = '{1'b0,1'b0,1'b1, 32'h0,32'h0,32'h200,32'hCAFE,ACCESS, 1'b1,1'b0,1'b1,1'b0, 32'h200,32'h0,32'h0,32'hCAFE,32'd2,32'd0};
        vecs[9] = '{1'b0,1'b0,1'b0, 32'h0,32'h0,32'h0,32'h0,FREE,     1'b1,1'b1,1'b0,1'b0, 32'h0,32'h0,32'h0,32'h0,32'd2,32'd1};

        // reset state
        reset_dut();
        set_in(1'b0,1'b0,1'b0, 32'h0,32'h0,32'h0,32'h0, FREE);
        chk("rst_waits",   {30'd0, bus.dwait, bus.iwait}, 32'd3);
        chk("rst_strobes", {30'd0, bus.ramREN, bus.ramWEN}, 32'd0);
        chk("rst_ramaddr", bus.ramaddr | bus.ramstore, 32'd0);
        chk("rst_loads",   bus.dload | bus.iload, 32'd0);
        chk("rst_err_cnt", {31'd0, bus_err} | dcount | icount, 32'd0);
        tick();

        // vector table: read with 2-cycle latency, write priority, instruction read
        for (int i = 0; i < 10; i++) begin
            set_in(vecs[i].d_ren, vecs[i].d_wen, vecs[i].i_ren, vecs[i].daddr,
                   vecs[i].dstore, vecs[i].iaddr, vecs[i].ramload, vecs[i].rs);
            chk($sformatf("vec%0d_dwait", i),  {31'd0, bus.dwait},  {31'd0, vecs[i].e_dwait});
            chk($sformatf("vec%0d_iwait", i),  {31'd0, bus.iwait},  {31'd0, vecs[i].e_iwait});
            chk($sformatf("vec%0d_ramREN", i), {31'd0, bus.ramREN}, {31'd0, vecs[i].e_ren});
            chk($sformatf("vec%0d_ramWEN", i), {31'd0, bus.ramWEN}, {31'd0, vecs[i].e_wen});
            chk($sformatf("vec%0d_ramaddr", i),  bus.ramaddr,  vecs[i].e_raddr);
            chk($sformatf("vec%0d_ramstore", i), bus.ramstore, vecs[i].e_rstore);
            chk($sformatf("vec%0d_dload", i),  bus.dload, vecs[i].e_dload);
            chk($sformatf("vec%0d_iload", i),  bus.iload, vecs[i].e_iload);
            chk($sformatf("vec%0d_dcount", i), dcount, vecs[i].e_dcnt);
            chk($sformatf("vec%0d_icount", i), icount, vecs[i].e_icnt);
            tick();
        end

        // round robin with both requests held: D,I,D,I at cycles 1,3,5,7
        reset_dut();
        seq = 4'd0; nrel = 0; last_c = 0;
        for (int c = 0; c < 20 && nrel < 4; c++) begin
            set_in(1'b1,1'b0,1'b1, 32'h10,32'h0,32'h20,32'h1, ACCESS);
            chk("rr_not_both_low", {31'd0, bus.dwait | bus.iwait}, 32'd1);
            if (!bus.dwait) begin seq[nrel] = 1'b0; nrel++; last_c = c; end
            else if (!bus.iwait) begin seq[nrel] = 1'b1; nrel++; last_c = c; end
            tick();
        end
        chk("rr_order", {28'd0, seq}, 32'h0000000A);
        chk("rr_count", 32'(nrel), 32'd4);
        chk("rr_last_cycle", 32'(last_c), 32'd7);

        // instruction grant stuck BUSY: watchdog forces completion
        reset_dut();
        n = 400; cap = 32'd0;
        for (int c = 0; c < 400; c++) begin
            set_in(1'b0,1'b0,1'b1, 32'h0,32'h0,32'h40,32'h0, BUSY);
            if (!bus.iwait) begin n = c; cap = bus.iload; break; end
            tick();
        end
        chk("wd_release_cycle", 32'(n), 32'd256);
        chk("wd_iload", cap, BAD_WORD);
        tick();
        set_in(1'b0,1'b0,1'b0, 32'h0,32'h0,32'h0,32'h0, FREE);
        chk("wd_bus_err", {31'd0, bus_err}, 32'd1);
        chk("wd_icount", icount, 32'd0);
        tick(); tick(); tick();
        chk("wd_bus_err_sticky", {31'd0, bus_err}, 32'd1);

        // RAM ERROR in data grant, then reset clears error and counters
        reset_dut();
        set_in(1'b1,1'b0,1'b0, 32'h80,32'h0,32'h0,32'h77, FREE);   tick();
        set_in(1'b1,1'b0,1'b0, 32'h80,32'h0,32'h0,32'h77, ACCESS); tick();
        set_in(1'b1,1'b0,1'b0, 32'h80,32'h0,32'h0,32'h77, FREE);   tick();
        set_in(1'b1,1'b0,1'b0, 32'h80,32'h0,32'h0,32'h77, ERROR);
        chk("err_dwait", {31'd0, bus.dwait}, 32'd0);
        chk("err_dload", bus.dload, BAD_WORD);
        tick();
        set_in(1'b1,1'b0,1'b0, 32'h80,32'h0,32'h0,32'h77, FREE);
        chk("err_bus_err", {31'd0, bus_err}, 32'd1);
        chk("err_dcount", dcount, 32'd1);
        RST = 1'b1; tick(); RST = 1'b0;
        set_in(1'b1,1'b0,1'b0, 32'h80,32'h0,32'h0,32'h77, FREE);
        chk("err_rst_bus_err", {31'd0, bus_err}, 32'd0);
        chk("err_rst_dcount", dcount, 32'd0);
        chk("err_rst_idle", {30'd0, bus.ramREN, bus.dwait}, 32'd1);
        tick();
        set_in(1'b1,1'b0,1'b0, 32'h80,32'h0,32'h0,32'h77, BUSY);
        chk("err_rst_grant_next", {31'd0, bus.ramREN}, 32'd1);
        tick();

        // request withdrawn mid-grant: no release, no count, back to IDLE
        reset_dut();
        saw_low = 1'b0;
        for (int c = 0; c < 4; c++) begin
            set_in(1'b1,1'b0,1'b0, 32'h90,32'h0,32'h0,32'h0, BUSY);
            saw_low = saw_low | ~bus.dwait; tick();
        end
        set_in(1'b0,1'b0,1'b0, 32'h90,32'h0,32'h0,32'h0, BUSY);
        saw_low = saw_low | ~bus.dwait; tick();
        set_in(1'b1,1'b0,1'b0, 32'h90,32'h0,32'h0,32'h0, ACCESS);
        saw_low = saw_low | ~bus.dwait;
        chk("wd_withdraw_idle", {31'd0, bus.ramREN}, 32'd0);
        chk("withdraw_no_release", {31'd0, saw_low}, 32'd0);
        chk("withdraw_dcount", dcount, 32'd0);
        tick();

        // reset during an instruction grant abandons it
        reset_dut();
        set_in(1'b0,1'b0,1'b1, 32'h0,32'h0,32'h44,32'h5, FREE); tick();
        set_in(1'b0,1'b0,1'b1, 32'h0,32'h0,32'h44,32'h5, BUSY); tick();
        RST = 1'b1;
        set_in(1'b0,1'b0,1'b1, 32'h0,32'h0,32'h44,32'h5, ACCESS);
        chk("rstg_iwait_during", {30'd0, bus.dwait, bus.iwait}, 32'd3);
        tick(); RST = 1'b0;
        set_in(1'b0,1'b0,1'b1, 32'h0,32'h0,32'h44,32'h5, ACCESS);
        chk("rstg_iwait_after", {30'd0, bus.dwait, bus.iwait}, 32'd3);
        chk("rstg_strobes", {30'd0, bus.ramREN, bus.ramWEN}, 32'd0);
        chk("rstg_icount", icount, 32'd0);
        tick();

        // randomized traffic against the transaction model
        reset_dut();
        r_d = 1'b0; r_w = 1'b0; r_i = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 1000 == 999) reset_dut();
            if ($urandom_range(7) == 0) r_d = ~r_d;
            if ($urandom_range(11) == 0) r_w = ~r_w;
            if ($urandom_range(7) == 0) r_i = ~r_i;
            x = $urandom_range(99);
            if (x < 45)      rs = BUSY;
            else if (x < 50) rs = FREE;
            else if (x < 98) rs = ACCESS;
            else             rs = ERROR;
            set_in(r_d, r_w, r_i, $urandom, $urandom, $urandom, $urandom, rs);
            model_check();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
